// File: rtl/iomem_pwm.sv
// ---------------------------------------------------------------------------
// iomem_pwm
//   Memory-mapped PWM LED driver on the PicoSoC iomem bus.
//   The block decodes the iomem window selected by iomem_addr[31:24] == BASE_ADDR.
//   Every selected transfer completes one cycle later with a one-cycle
//   iomem_ready pulse. iomem_rdata always returns the value the register held
//   before the write.
//   The block drives NCH glitch-free PWM outputs. Their duty values are
//   shadowed and only take effect when the PWM counter wraps.
//
// Register map (offset = addr[7:0], addr[1:0] and addr[23:8] ignored)
//   0x00        CTRL      bit0 enable, bit1 invert
//   0x04        PRESCALE  16 bits; a counter tick every PRESCALE+1 cycles
//   0x08        COUNT     read-only, current PWM counter
//   0x10+4*i    DUTY[i]   WIDTH bits, i < NCH
//   others      read 0, writes ignored, still acknowledged
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   iomem_valid  bus request valid
//   iomem_ready  one-cycle transfer-complete pulse
//   iomem_wstrb  byte write strobes (0 = read)
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready = 1
//   pwm_out      registered PWM outputs
//   period_tick  one-cycle pulse after each PWM period wrap
// ---------------------------------------------------------------------------
module iomem_pwm #(
    parameter int          NCH       = 8,
    parameter int          WIDTH     = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h04
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    output logic [NCH-1:0]   pwm_out,
    output logic             period_tick
);

    // Bus handshake state
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;

    // Programmable registers
    logic [1:0]       ctrl_q, ctrl_d;
    logic [15:0]      prescale_q, prescale_d;
    logic [WIDTH-1:0] duty_q   [NCH];
    logic [WIDTH-1:0] duty_d   [NCH];
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];

    // Counters and outputs
    logic [15:0]      pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [NCH-1:0]   pwm_out_q, pwm_out_d;
    logic             period_tick_q, period_tick_d;

    // Decode and datapath helpers
    logic             sel;
    logic             is_write;
    logic [5:0]       word_idx;
    logic [31:0]      read_val;
    logic [31:0]      lane_mask;
    logic [31:0]      wr_word;
    logic             enable;
    logic             invert;
    logic             tick;
    logic             wrap;

    assign enable   = ctrl_q[0];
    assign invert   = ctrl_q[1];
    assign word_idx = iomem_addr[7:2];
    assign is_write = |iomem_wstrb;

    // Gating on !ready_q keeps a held valid from re-triggering in the cycle
    // the acknowledge is visible. This spaces transfers at least two cycles apart.
    assign sel = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);

    // Pre-write value of the addressed register; also the base for byte merging
    always_comb begin
        read_val = '0;
        case (word_idx)
            6'd0:    read_val = {30'd0, ctrl_q};
            6'd1:    read_val = {16'd0, prescale_q};
            6'd2:    read_val = 32'(pwm_cnt_q);
            default: read_val = '0;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (word_idx == 6'(i + 4)) begin
                read_val = 32'(duty_q[i]);
            end
        end
    end

    // Byte-lane merge. The result is later truncated to the register width,
    // so strobes on lanes above the register width have no effect.
    assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                        {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wr_word   = (read_val & ~lane_mask) | (iomem_wdata & lane_mask);

    // Register writes and bus response
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        for (int i = 0; i < NCH; i++) begin
            duty_d[i] = duty_q[i];
        end
        if (sel && is_write) begin
            case (word_idx)
                6'd0:    ctrl_d     = wr_word[1:0];
                6'd1:    prescale_d = wr_word[15:0];
                default: ;
            endcase
            for (int i = 0; i < NCH; i++) begin
                if (word_idx == 6'(i + 4)) begin
                    duty_d[i] = wr_word[WIDTH-1:0];
                end
            end
        end
        ready_d = sel;
        rdata_d = sel ? read_val : '0;
    end

    // Prescaler and PWM counter. The >= compare guarantees that lowering
    // PRESCALE below the current pre_cnt ticks immediately, so the count never stalls.
    always_comb begin
        tick          = 1'b0;
        wrap          = 1'b0;
        pre_cnt_d     = '0;
        pwm_cnt_d     = '0;
        if (enable) begin
            tick      = (pre_cnt_q >= prescale_q);
            pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
            pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
            wrap      = tick && (pwm_cnt_q == '1);
        end
        period_tick_d = wrap;
        // Shadows track DUTY continuously while disabled, so enabling starts
        // with current duties. While enabled, the shadows only reload on a wrap.
        // They take the pre-write DUTY, so a write on a wrap edge lands one period later.
        for (int i = 0; i < NCH; i++) begin
            shadow_d[i] = (!enable || wrap) ? duty_q[i] : shadow_q[i];
        end
    end

    // Per-channel comparator. A disabled block drives the invert level on every channel.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign pwm_out_d[gi] = (enable && (pwm_cnt_q < shadow_q[gi])) ^ invert;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q       <= 1'b0;
            rdata_q       <= '0;
            ctrl_q        <= '0;
            prescale_q    <= '0;
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            pwm_out_q     <= '0;
            period_tick_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            ready_q       <= ready_d;
            rdata_q       <= rdata_d;
            ctrl_q        <= ctrl_d;
            prescale_q    <= prescale_d;
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pwm_out_q     <= pwm_out_d;
            period_tick_q <= period_tick_d;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i]   <= duty_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign pwm_out     = pwm_out_q;
    assign period_tick = period_tick_q;

endmodule

// File: tb/tb_iomem_pwm.sv
// ---------------------------------------------------------------------------
// tb_iomem_pwm
//   Self-checking bench for iomem_pwm.
//   Register behaviour is compared against a word-level register model.
//   PWM behaviour is checked per period against the arithmetic expectations:
//     period length = 2^WIDTH * (PRESCALE+1) cycles
//     high time     = DUTY * (PRESCALE+1) cycles, in a single contiguous run
// ---------------------------------------------------------------------------
module tb_iomem_pwm;
    localparam int NCH    = 8;
    localparam int WIDTH  = 8;
    localparam int PERIOD = 1 << WIDTH;
    localparam logic [31:0] BASE = 32'h0400_0000;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             iomem_valid = 1'b0;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb = 4'h0;
    logic [31:0]      iomem_addr = '0;
    logic [31:0]      iomem_wdata = '0;
    logic [31:0]      iomem_rdata;
    logic [NCH-1:0]   pwm_out;
    logic             period_tick;

    iomem_pwm #(.NCH(NCH), .WIDTH(WIDTH), .BASE_ADDR(8'h04)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] rd;
    int          lat;

    // Register model, indexed by word offset (addr[7:2])
    logic [31:0] reg_m [64];

    // Per-period measurements
    int win_len  [4];
    int win_high [4][NCH];
    int win_rise [4][NCH];

    function automatic logic [31:0] reg_mask(input int idx);
        if (idx == 0) return 32'h3;
        if (idx == 1) return 32'hFFFF;
        if (idx >= 4 && idx < 4 + NCH) return (32'd1 << WIDTH) - 32'd1;
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) reg_m[i] = '0;
    endtask

    task automatic model_wr(input int idx, input logic [3:0] strb, input logic [31:0] data);
        logic [31:0] keep;
        keep = '0;
        for (int b = 0; b < 4; b++) if (!strb[b]) keep = keep | (32'hFF << (8 * b));
        reg_m[idx] = ((reg_m[idx] & keep) | (data & ~keep)) & reg_mask(idx);
    endtask

    // One bus transfer; latency is the number of cycles from valid to ready (-1 = none)
    task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                       output logic [31:0] rdv, output int latency);
        @(negedge clk);
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wd;
        iomem_valid = 1'b1;
        latency = -1;
        rdv = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (iomem_ready) begin
                latency = c;
                rdv = iomem_rdata;
                break;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        $display("[TB] bus addr=%08h wstrb=%h wdata=%08h rdata=%08h latency=%0d",
                 addr, strb, wd, rdv, latency);
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        bus(BASE | 32'(idx << 2), 4'hF, data, rd, lat);
        model_wr(idx, 4'hF, data);
    endtask

    // Wait for a period_tick, then measure n consecutive tick-to-tick windows
    task automatic measure(input int n);
        int guard;
        logic [NCH-1:0] prev;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!period_tick && guard < 3000);
        tests_run++;
        if (!period_tick) begin
            tests_failed++;
            $display("FAIL period_tick_wait: no tick within %0d cycles, required one", guard);
            return;
        end
        for (int w = 0; w < n; w++) begin
            win_len[w] = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                win_high[w][ch] = 0;
                win_rise[w][ch] = 0;
            end
            prev = pwm_out;
            do begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (pwm_out[ch]) win_high[w][ch]++;
                    if (pwm_out[ch] && !prev[ch]) win_rise[w][ch]++;
                end
                prev = pwm_out;
                win_len[w]++;
                @(negedge clk);
            end while (!period_tick && win_len[w] < 3000);
        end
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4];
        addrs[0] = 32'h0400_0000; addrs[1] = 32'h0400_0004;
        addrs[2] = 32'h0400_0008; addrs[3] = 32'h0400_0010;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        tests_run++;
        if (pwm_out !== '0 || period_tick !== 1'b0 || iomem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pwm_out=%h tick=%b ready=%b, required 0/0/0",
                     pwm_out, period_tick, iomem_ready);
        end
        for (int i = 0; i < 4; i++) begin
            bus(addrs[i], 4'h0, '0, rd, lat);
            tests_run++;
            if (lat !== 1 || rd !== 32'h0 || pwm_out !== '0) begin
                tests_failed++;
                $display("FAIL reset_read %08h: rdata=%h lat=%0d pwm=%h, required 0/1/0",
                         addrs[i], rd, lat, pwm_out);
            end
        end
    endtask

    task automatic test_byte_lanes();
        bus(BASE | 32'h4, 4'b0001, 32'hAABBCCDD, rd, lat);
        model_wr(1, 4'b0001, 32'hAABBCCDD);
        bus(BASE | 32'h4, 4'h0, '0, rd, lat);
        tests_run++;
        if (rd !== reg_m[1] || rd !== 32'h0000_00DD) begin
            tests_failed++;
            $display("FAIL lane_0001: got %08h, required 000000dd", rd);
        end
        bus(BASE | 32'h4, 4'b0110, 32'hAABBCCDD, rd, lat);
        tests_run++;
        if (rd !== 32'h0000_00DD) begin
            tests_failed++;
            $display("FAIL lane_prewrite: got %08h, required 000000dd", rd);
        end
        model_wr(1, 4'b0110, 32'hAABBCCDD);
        bus(BASE | 32'h4, 4'h0, '0, rd, lat);
        tests_run++;
        if (rd !== reg_m[1] || rd !== 32'h0000_CCDD) begin
            tests_failed++;
            $display("FAIL lane_0110: got %08h, required 0000ccdd", rd);
        end
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        iomem_addr  = 32'h0300_0004;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h1234_5678;
        iomem_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (iomem_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL foreign_ready cycle %0d: got %b, required 0", c, iomem_ready);
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        // Upper address bits 23:8 are ignored inside the window
        bus(32'h04FF_FF04, 4'h0, '0, rd, lat);
        tests_run++;
        if (rd !== reg_m[1] || lat !== 1) begin
            tests_failed++;
            $display("FAIL foreign_nochange: prescale=%08h lat=%0d, required %08h/1", rd, lat, reg_m[1]);
        end
        bus(BASE | 32'h40, 4'hF, 32'hDEADBEEF, rd, lat);
        tests_run++;
        if (lat !== 1 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL unmapped_write: lat=%0d rdata=%08h, required 1/0", lat, rd);
        end
        @(negedge clk);
        tests_run++;
        if (iomem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_single_pulse: got %b, required 0", iomem_ready);
        end
        bus(BASE | 32'h40, 4'h0, '0, rd, lat);
        tests_run++;
        if (rd !== 32'h0 || lat !== 1) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %08h lat=%0d, required 0/1", rd, lat);
        end
    endtask

    task automatic test_reg_random();
        int r, idx;
        logic [3:0]  strb;
        logic [31:0] data, addr, exp;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 11);
            if (r <= 1)       idx = r;
            else if (r <= 9)  idx = 4 + (r - 2);
            else if (r == 10) idx = 3;
            else              idx = 16;
            strb = 4'($urandom_range(0, 15));
            data = $urandom;
            addr = BASE | (32'($urandom_range(0, 65535)) << 8) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            exp  = reg_m[idx];
            bus(addr, strb, data, rd, lat);
            tests_run++;
            if (rd !== exp || lat !== 1) begin
                tests_failed++;
                $display("FAIL reg_random idx=%0d: rdata=%08h lat=%0d, required %08h/1", idx, rd, lat, exp);
            end
            if (strb != 4'h0) model_wr(idx, strb, data);
        end
        wr(0, 0);
        for (int i = 0; i < 4 + NCH; i++) begin
            if (i == 2) continue;
            bus(BASE | 32'(i << 2), 4'h0, '0, rd, lat);
            tests_run++;
            if (rd !== reg_m[i]) begin
                tests_failed++;
                $display("FAIL reg_readback idx=%0d: got %08h, required %08h", i, rd, reg_m[i]);
            end
        end
    endtask

    task automatic test_pwm_basic();
        wr(0, 0);
        wr(1, 0);
        wr(4, 64);
        wr(5, 0);
        for (int ch = 2; ch < 7; ch++) wr(4 + ch, $urandom_range(0, PERIOD - 1));
        wr(4 + 7, PERIOD - 1);
        wr(0, 1);
        measure(2);
        for (int w = 0; w < 2; w++) begin
            tests_run++;
            if (win_len[w] !== PERIOD) begin
                tests_failed++;
                $display("FAIL basic_period w%0d: got %0d cycles, required %0d", w, win_len[w], PERIOD);
            end
            for (int ch = 0; ch < NCH; ch++) begin
                tests_run++;
                if (win_high[w][ch] !== int'(reg_m[4 + ch]) || win_rise[w][ch] > 1) begin
                    tests_failed++;
                    $display("FAIL basic_high w%0d ch%0d: high=%0d rises=%0d, required %0d/<=1",
                             w, ch, win_high[w][ch], win_rise[w][ch], reg_m[4 + ch]);
                end
            end
        end
    endtask

    task automatic test_count();
        logic [31:0] c1;
        bus(BASE | 32'h8, 4'h0, '0, c1, lat);
        bus(BASE | 32'h8, 4'hF, 32'hFFFF_FFFF, rd, lat);
        tests_run++;
        if (((rd - c1) & 32'hFF) !== 32'd2) begin
            tests_failed++;
            $display("FAIL count_advance: %0d then %0d, required +2 mod 256", c1, rd);
        end
    endtask

    task automatic test_duty_update();
        logic [31:0] wrd;
        int wlat, guard;
        wr(0, 0);
        wr(1, 3);
        wr(4, 128);
        wr(0, 1);
        fork
            measure(2);
            begin
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (!period_tick && guard < 3000);
                repeat (200) @(negedge clk);
                bus(BASE | 32'h10, 4'hF, 32'd32, wrd, wlat);
            end
        join
        for (int w = 0; w < 2; w++) begin
            tests_run++;
            if (win_len[w] !== 4 * PERIOD) begin
                tests_failed++;
                $display("FAIL update_period w%0d: got %0d, required %0d", w, win_len[w], 4 * PERIOD);
            end
            for (int ch = 1; ch < NCH; ch++) begin
                tests_run++;
                if (win_high[w][ch] !== 4 * int'(reg_m[4 + ch])) begin
                    tests_failed++;
                    $display("FAIL update_other w%0d ch%0d: got %0d, required %0d",
                             w, ch, win_high[w][ch], 4 * reg_m[4 + ch]);
                end
            end
        end
        tests_run++;
        if (win_high[0][0] !== 512) begin
            tests_failed++;
            $display("FAIL update_old_duty: got %0d high cycles, required 512", win_high[0][0]);
        end
        tests_run++;
        if (win_high[1][0] !== 128) begin
            tests_failed++;
            $display("FAIL update_new_duty: got %0d high cycles, required 128", win_high[1][0]);
        end
        model_wr(4, 4'hF, 32'd32);
    endtask

    task automatic test_pwm_random();
        int p;
        for (int round = 0; round < 2; round++) begin
            wr(0, 0);
            p = $urandom_range(0, 3);
            wr(1, p);
            for (int ch = 0; ch < NCH; ch++) wr(4 + ch, $urandom_range(0, PERIOD - 1));
            wr(0, 1);
            measure(1);
            tests_run++;
            if (win_len[0] !== PERIOD * (p + 1)) begin
                tests_failed++;
                $display("FAIL rand_period p=%0d: got %0d, required %0d", p, win_len[0], PERIOD * (p + 1));
            end
            for (int ch = 0; ch < NCH; ch++) begin
                tests_run++;
                if (win_high[0][ch] !== int'(reg_m[4 + ch]) * (p + 1) || win_rise[0][ch] > 1) begin
                    tests_failed++;
                    $display("FAIL rand_high p=%0d ch%0d: high=%0d rises=%0d, required %0d/<=1",
                             p, ch, win_high[0][ch], win_rise[0][ch], int'(reg_m[4 + ch]) * (p + 1));
                end
            end
        end
    endtask

    task automatic test_disabled();
        int ticks;
        wr(0, 2);
        repeat (2) @(negedge clk);
        ticks = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (period_tick) ticks++;
        end
        tests_run++;
        if (pwm_out !== {NCH{1'b1}} || ticks !== 0) begin
            tests_failed++;
            $display("FAIL disabled_invert: pwm=%h ticks=%0d, required ff/0", pwm_out, ticks);
        end
        bus(BASE | 32'h8, 4'h0, '0, rd, lat);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL disabled_count: got %0d, required 0", rd);
        end
        wr(0, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (pwm_out !== '0) begin
            tests_failed++;
            $display("FAIL disabled_plain: pwm=%h, required 0", pwm_out);
        end
    endtask

    task automatic test_async_reset();
        wr(1, 0);
        wr(4, 64);
        wr(5, 0);
        wr(0, 3);
        measure(1);
        tests_run++;
        if (win_high[0][0] !== PERIOD - 64 || win_high[0][1] !== PERIOD) begin
            tests_failed++;
            $display("FAIL invert_high: ch0=%0d ch1=%0d, required %0d/%0d",
                     win_high[0][0], win_high[0][1], PERIOD - 64, PERIOD);
        end
        repeat (100) @(negedge clk);
        iomem_addr  = BASE;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        @(posedge clk);
        #2;
        tests_run++;
        if (iomem_ready !== 1'b1 || pwm_out[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_state: ready=%b pwm1=%b, required 1/1", iomem_ready, pwm_out[1]);
        end
        resetn = 1'b0;
        iomem_valid = 1'b0;
        #1;
        tests_run++;
        if (iomem_ready !== 1'b0 || pwm_out !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: ready=%b pwm=%h, required 0/0", iomem_ready, pwm_out);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (iomem_ready !== 1'b0 || pwm_out !== '0) begin
                tests_failed++;
                $display("FAIL post_reset cycle %0d: ready=%b pwm=%h, required 0/0", c, iomem_ready, pwm_out);
            end
        end
        for (int i = 0; i < 4 + NCH; i++) begin
            bus(BASE | 32'(i << 2), 4'h0, '0, rd, lat);
            tests_run++;
            if (rd !== 32'h0 || lat !== 1) begin
                tests_failed++;
                $display("FAIL post_reset_reg idx=%0d: got %08h lat=%0d, required 0/1", i, rd, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_unmapped();
        test_reg_random();
        test_pwm_basic();
        test_count();
        test_duty_update();
        test_pwm_random();
        test_disabled();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
